// File: rtl/m_frame_scheduler.sv
// Frame sequencer: a free-running frame tick starts one game-logic step and
// then one renderer pass per frame. It also runs a watchdog on each phase,
// flags overrun when a tick arrives while the previous one is still pending,
// and counts completed frames.
module m_frame_scheduler #(
  parameter int TICKS_PER_FRAME = 833333,
  parameter int TICK_W          = 20,
  parameter int TIMEOUT         = 65535,
  parameter int TO_W            = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
  input  logic        clr_status,
  output logic        logic_enable,
  input  logic        logic_done,
  output logic        render_enable,
  input  logic        render_finished,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        overrun,
  output logic        fault
);

  typedef enum logic [1:0] {S_WAIT, S_LOGIC, S_RENDER} state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_FRAME - 1);
  localparam logic [TO_W-1:0]   WD_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   WD_MAX    = '1;

  state_t            state, state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic [TO_W-1:0]   wd_cnt, wd_nxt;
  logic              pending;
  logic              tick, wd_expired;
  logic              consume, frame_done, abort;

  assign tick       = (tick_cnt == TICK_LAST);
  assign wd_expired = (wd_cnt == WD_LAST);

  // Frame-period counter, independent of state and run.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Next-state, watchdog and frame events. A done flag in the same cycle as
  // watchdog expiry takes priority, so a phase finishing on its last allowed
  // cycle still counts as a success.
  always_comb begin
    state_nxt  = state;
    wd_nxt     = wd_cnt;
    consume    = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    case (state)
      S_WAIT: begin
        if (run && pending) begin
          state_nxt = S_LOGIC;
          wd_nxt    = '0;
          consume   = 1'b1;
        end
      end
      S_LOGIC: begin
        if (logic_done) begin
          state_nxt = S_RENDER;
          wd_nxt    = '0;
        end else if (wd_expired) begin
          state_nxt = S_WAIT;
          wd_nxt    = '0;
          abort     = 1'b1;
        end else if (wd_cnt != WD_MAX) begin
          wd_nxt = wd_cnt + TO_W'(1);
        end
      end
      S_RENDER: begin
        if (render_finished) begin
          state_nxt  = S_WAIT;
          wd_nxt     = '0;
          frame_done = 1'b1;
        end else if (wd_expired) begin
          state_nxt = S_WAIT;
          wd_nxt    = '0;
          abort     = 1'b1;
        end else if (wd_cnt != WD_MAX) begin
          wd_nxt = wd_cnt + TO_W'(1);
        end
      end
      default: begin
        state_nxt = S_WAIT;
        wd_nxt    = '0;
      end
    endcase
  end

  // State and the decoded enables are registered together so logic_enable
  // falls on the very edge render_enable rises.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= S_WAIT;
      wd_cnt        <= '0;
      logic_enable  <= 1'b0;
      render_enable <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      wd_cnt        <= wd_nxt;
      logic_enable  <= (state_nxt == S_LOGIC);
      render_enable <= (state_nxt == S_RENDER);
      busy          <= (state_nxt != S_WAIT);
    end
  end

  // Pending tick: a tick landing on the consume cycle re-arms it; ticks never queue.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) pending <= 1'b0;
    else         pending <= tick | (pending & ~consume);
  end

  // Sticky status flags; a set event in the same cycle beats clr_status.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overrun <= 1'b0;
      fault   <= 1'b0;
    end else begin
      if (tick && pending && !consume) overrun <= 1'b1;
      else if (clr_status)             overrun <= 1'b0;
      if (abort)           fault <= 1'b1;
      else if (clr_status) fault <= 1'b0;
    end
  end

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)         frame_count <= '0;
    else if (frame_done) frame_count <= frame_count + 16'd1;
  end

endmodule

// File: tb/tb_m_frame_scheduler.sv
// Bench for m_frame_scheduler: directed frame scenarios with cycle-exact
// expectations, plus a randomized run against an interval-based frame model.
module tb_m_frame_scheduler;
  localparam int TPF = 16;
  localparam int TO  = 40;

  logic        clock = 1'b0, resetn = 1'b0, run = 1'b0, clr_status = 1'b0;
  logic        logic_done, render_finished;
  logic        logic_enable, render_enable, busy, overrun, fault;
  logic [15:0] frame_count;

  int checks = 0, errors = 0;
  int fix_l = 3, fix_r = 10, cur_l = 3, cur_r = 10;
  int lcnt, rcnt;

  // Reference model: a frame is an interval of cycles (start, logic end, render end).
  int          m_c = 0, m_lend = 0, m_rend = 0;
  bit          m_active = 0, m_pend = 0, m_le = 0, m_re = 0, m_ovr = 0, m_flt = 0;
  bit          m_lflt = 0, m_rflt = 0, m_tk, m_cons, m_fset, m_oset;
  logic [15:0] m_fc = '0;

  always #5 clock = ~clock;

  m_frame_scheduler #(.TICKS_PER_FRAME(TPF), .TICK_W(4), .TIMEOUT(TO), .TO_W(6)) dut (
    .clock(clock), .resetn(resetn), .run(run), .clr_status(clr_status),
    .logic_enable(logic_enable), .logic_done(logic_done),
    .render_enable(render_enable), .render_finished(render_finished),
    .busy(busy), .frame_count(frame_count), .overrun(overrun), .fault(fault));

  // Responders: answer after cur_l / cur_r cycles of their enable being high.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin lcnt <= 0; rcnt <= 0; end
    else begin
      lcnt <= logic_enable  ? lcnt + 1 : 0;
      rcnt <= render_enable ? rcnt + 1 : 0;
    end
  end
  assign logic_done      = logic_enable  && (lcnt == cur_l - 1);
  assign render_finished = render_enable && (rcnt == cur_r - 1);

  // Model advances mid-cycle using this cycle's inputs; its m_* then describe the next cycle.
  always @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      m_c = 0; m_active = 0; m_pend = 0; m_le = 0; m_re = 0;
      m_ovr = 0; m_flt = 0; m_fc = '0;
    end else begin
      m_tk   = (m_c % TPF) == TPF - 1;
      m_cons = !m_active && run && m_pend;
      m_fset = 0;
      if (m_cons) begin
        cur_l    = (fix_l != 0) ? fix_l : int'($urandom_range(1, 45));
        cur_r    = (fix_r != 0) ? fix_r : int'($urandom_range(1, 45));
        m_lflt   = cur_l > TO;
        m_rflt   = !m_lflt && cur_r > TO;
        m_lend   = m_c + (m_lflt ? TO : cur_l);
        m_rend   = m_lend + (m_lflt ? 0 : (m_rflt ? TO : cur_r));
        m_active = 1;
      end else if (m_active && m_c == m_rend) begin
        m_active = 0;
        if (m_lflt || m_rflt) m_fset = 1;
        else                  m_fc = m_fc + 16'd1;
      end
      m_oset = m_tk && m_pend && !m_cons;
      m_pend = m_cons ? m_tk : (m_pend | m_tk);
      m_ovr  = m_oset | (m_ovr & ~clr_status);
      m_flt  = m_fset | (m_flt & ~clr_status);
      m_c++;
      m_le = m_active && m_c <= m_lend;
      m_re = m_active && m_c > m_lend;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Leaves the bench at cycle 0 (just after reset release).
  task automatic do_reset();
    resetn = 1'b0; run = 1'b0; clr_status = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; run = 1'b1;
    cyc(3);
    checks++; if (logic_enable !== 1'b0) begin errors++; $display("FAIL reset_le got %b exp 0", logic_enable); end
    checks++; if (render_enable !== 1'b0) begin errors++; $display("FAIL reset_re got %b exp 0", render_enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_fc got %0d exp 0", frame_count); end
    checks++; if ({overrun, fault} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overrun, fault}); end
  endtask

  task automatic test_basic();
    int k;
    fix_l = 3; fix_r = 10;
    do_reset(); run = 1'b1;
    k = 0;
    while (logic_enable !== 1'b1 && k < 100) begin cyc(1); k++; end
    checks++; if (k !== 17) begin errors++; $display("FAIL basic_first_logic got cycle %0d exp 17", k); end
    cyc(2); // cycle 19
    checks++; if ({logic_enable, render_enable} !== 2'b10) begin errors++; $display("FAIL basic_c19 got %b exp 10", {logic_enable, render_enable}); end
    cyc(1); // cycle 20: handoff
    checks++; if ({logic_enable, render_enable} !== 2'b01) begin errors++; $display("FAIL basic_handoff got %b exp 01", {logic_enable, render_enable}); end
    cyc(9); // cycle 29
    checks++; if ({render_enable, frame_count} !== {1'b1, 16'd0}) begin errors++; $display("FAIL basic_c29 got re=%b fc=%0d exp re=1 fc=0", render_enable, frame_count); end
    cyc(1); // cycle 30
    checks++; if ({render_enable, busy, frame_count} !== {2'b00, 16'd1}) begin errors++; $display("FAIL basic_c30 got re=%b busy=%b fc=%0d exp 0 0 1", render_enable, busy, frame_count); end
    cyc(34); // cycle 64
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL basic_fc3 got %0d exp 3", frame_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_overrun();
    fix_l = 3; fix_r = 30;
    do_reset(); run = 1'b1;
    cyc(47);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_c47 got %b exp 0", overrun); end
    cyc(1); // cycle 48
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_c48 got %b exp 1", overrun); end
    cyc(2); // cycle 50
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_wait50 got busy=%b exp 0", busy); end
    cyc(1); // cycle 51
    checks++; if (logic_enable !== 1'b1) begin errors++; $display("FAIL ovr_consume got le=%b exp 1", logic_enable); end
    cyc(4); clr_status = 1'b1;
    cyc(1); clr_status = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
  endtask

  task automatic test_timeout();
    fix_l = 3; fix_r = 1000;
    do_reset(); run = 1'b1;
    cyc(20);
    checks++; if (render_enable !== 1'b1) begin errors++; $display("FAIL to_rise got %b exp 1", render_enable); end
    cyc(39); // cycle 59
    checks++; if ({render_enable, fault} !== 2'b10) begin errors++; $display("FAIL to_c59 got %b exp 10", {render_enable, fault}); end
    cyc(1); // cycle 60
    checks++; if ({render_enable, busy, fault} !== 3'b001) begin errors++; $display("FAIL to_abort got %b exp 001", {render_enable, busy, fault}); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL to_fc got %0d exp 0", frame_count); end
    fix_r = 10;
    cyc(1); // cycle 61
    checks++; if (logic_enable !== 1'b1) begin errors++; $display("FAIL to_next_frame got le=%b exp 1", logic_enable); end
  endtask

  task automatic test_done_vs_timeout();
    fix_l = 40; fix_r = 40;
    do_reset(); run = 1'b1;
    cyc(57);
    checks++; if ({render_enable, fault} !== 2'b10) begin errors++; $display("FAIL dvt_logic got %b exp 10", {render_enable, fault}); end
    cyc(40); // cycle 97
    checks++; if ({busy, fault, frame_count} !== {2'b00, 16'd1}) begin errors++; $display("FAIL dvt_render got busy=%b fault=%b fc=%0d exp 0 0 1", busy, fault, frame_count); end
  endtask

  task automatic test_run_stop();
    int hits;
    fix_l = 3; fix_r = 10;
    do_reset(); run = 1'b1;
    cyc(22); run = 1'b0;
    cyc(8); // cycle 30
    checks++; if ({busy, frame_count} !== {1'b0, 16'd1}) begin errors++; $display("FAIL stop_complete got busy=%b fc=%0d exp 0 1", busy, frame_count); end
    hits = 0;
    for (int i = 31; i <= 70; i++) begin cyc(1); if (logic_enable === 1'b1) hits++; end
    checks++; if (hits !== 0) begin errors++; $display("FAIL stop_hold got %0d logic cycles exp 0", hits); end
    run = 1'b1; // cycle 70
    cyc(1);
    checks++; if (logic_enable !== 1'b1) begin errors++; $display("FAIL stop_resume got le=%b exp 1", logic_enable); end
  endtask

  task automatic test_tick_consume();
    int ovr_seen;
    fix_l = 5; fix_r = 25;
    do_reset(); run = 1'b1;
    cyc(47);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tc_wait got busy=%b exp 0", busy); end
    cyc(1); // cycle 48
    checks++; if (logic_enable !== 1'b1) begin errors++; $display("FAIL tc_start got le=%b exp 1", logic_enable); end
    ovr_seen = (overrun === 1'b1) ? 1 : 0;
    for (int i = 49; i <= 63; i++) begin cyc(1); if (overrun === 1'b1) ovr_seen++; end
    checks++; if (ovr_seen !== 0) begin errors++; $display("FAIL tc_no_overrun got %0d cycles high exp 0", ovr_seen); end
    cyc(15); // cycle 78
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tc_wait78 got busy=%b exp 0", busy); end
    cyc(1);
    checks++; if (logic_enable !== 1'b1) begin errors++; $display("FAIL tc_back_to_back got le=%b exp 1", logic_enable); end
  endtask

  task automatic test_reset_mid();
    int k;
    fix_l = 3; fix_r = 10;
    do_reset(); run = 1'b1;
    cyc(34);
    checks++; if ({logic_enable, frame_count} !== {1'b1, 16'd1}) begin errors++; $display("FAIL rmid_pre got le=%b fc=%0d exp 1 1", logic_enable, frame_count); end
    #1 resetn = 1'b0;
    #1;
    checks++; if ({logic_enable, busy, frame_count} !== {2'b00, 16'd0}) begin errors++; $display("FAIL rmid_async got le=%b busy=%b fc=%0d exp 0 0 0", logic_enable, busy, frame_count); end
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    k = 0;
    while (logic_enable !== 1'b1 && k < 100) begin cyc(1); k++; end
    checks++; if (k !== 17) begin errors++; $display("FAIL rmid_restart got cycle %0d exp 17", k); end
  endtask

  task automatic test_random();
    fix_l = 0; fix_r = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      run        = ($urandom_range(0, 9) != 0);
      clr_status = ($urandom_range(0, 15) == 0);
      cyc(1);
      checks++;
      if ({logic_enable, render_enable, busy} !== {m_le, m_re, m_le | m_re}) begin
        errors++; $display("FAIL rnd_enables cycle %0d got %b exp %b", m_c, {logic_enable, render_enable, busy}, {m_le, m_re, m_le | m_re});
      end
      checks++;
      if ({overrun, fault} !== {m_ovr, m_flt}) begin
        errors++; $display("FAIL rnd_flags cycle %0d got %b exp %b", m_c, {overrun, fault}, {m_ovr, m_flt});
      end
      checks++;
      if (frame_count !== m_fc) begin
        errors++; $display("FAIL rnd_fc cycle %0d got %0d exp %0d", m_c, frame_count, m_fc);
      end
    end
    clr_status = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_timeout();
    test_done_vs_timeout();
    test_run_stop();
    test_tick_consume();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
